// File: rtl/ring_pkg.sv
// Shared ring definitions: slot type codes, scheduler state encoding and the
// layout of a 40-bit queue entry.
package ring_pkg;

  typedef enum logic [3:0] {
    SLOT_TOKEN      = 4'd1,
    SLOT_ADDRESS    = 4'd2,
    SLOT_WRITE_DATA = 4'd3,
    SLOT_NULL       = 4'd7
  } slot_type_t;

  typedef enum logic {
    ST_INJECT     = 1'b0,
    ST_WAIT_TOKEN = 1'b1
  } sched_state_t;

  // Queue entry as presented by the resend / directory-notify queues.
  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  kind;
    logic [31:0] data;
  } queue_word_t;

endpackage

// File: rtl/ring_rr_arb.sv
// Two-input priority arbiter whose priority flips each time toggle is pulsed.
// Priority starts with requester A after reset.
module ring_rr_arb (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  input  logic toggle,
  output logic grant_a,
  output logic grant_b,
  output logic pri_b
);

  // Priority register: A after reset, flips on every toggle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      pri_b <= 1'b0;
    end else if (toggle) begin
      pri_b <= ~pri_b;
    end
  end

  // Grant the priority requester if it is asking, otherwise the other one.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (enable) begin
      if (pri_b) begin
        if (req_b)      grant_b = 1'b1;
        else if (req_a) grant_a = 1'b1;
      end else begin
        if (req_a)      grant_a = 1'b1;
        else if (req_b) grant_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_slot_sched.sv
// Ring head slot scheduler: injects bursts from two queues, then emits a Token
// and forwards ring traffic until the Token returns or a watchdog expires.
// Optional statistics counters are built only when RING_SLOT_SCHED_STATS_EN is
// defined.
module ring_slot_sched
  import ring_pkg::*;
#(
  parameter int unsigned MAX_BURST     = 8,
  parameter int unsigned TOKEN_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ringIn,
  input  logic [3:0]  slotTypeIn,
  input  logic [3:0]  sourceIn,
  output logic [31:0] ringOut,
  output logic [3:0]  slotTypeOut,
  output logic [3:0]  sourceOut,
  input  logic        aValid,
  input  logic [39:0] aData,
  output logic        aRead,
  input  logic        bValid,
  input  logic [39:0] bData,
  output logic        bRead,
  output logic        tokenLost,
  output logic [31:0] statA,
  output logic [31:0] statB,
  output logic [31:0] statRounds
);

  localparam logic [3:0]  BURST_LIMIT  = 4'(MAX_BURST);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TOKEN_TIMEOUT - 1);

  sched_state_t state, state_next;
  logic [3:0]   burst, burst_next;
  logic [15:0]  wd, wd_next;
  logic [31:0]  ring_next;
  logic [3:0]   type_next;
  logic [3:0]   src_next;
  logic         lost_next;

  logic        grant_a, grant_b, pri_b;
  logic        burst_full, emit_token, arb_enable;
  logic        token_in, drop_addr;
  queue_word_t word_sel;

  assign burst_full = (burst == BURST_LIMIT);
  assign emit_token = (state == ST_INJECT) && (burst_full || !(aValid || bValid));
  // Reset gating keeps the pop strobes quiet while reset is held.
  assign arb_enable = (state == ST_INJECT) && !burst_full && !reset;
  assign token_in   = (slotTypeIn == SLOT_TOKEN);
  assign drop_addr  = (slotTypeIn == SLOT_ADDRESS) && ringIn[31];

  ring_rr_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .enable  (arb_enable),
    .req_a   (aValid),
    .req_b   (bValid),
    .toggle  (emit_token && !reset),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .pri_b   (pri_b)
  );

  assign aRead    = grant_a;
  assign bRead    = grant_b;
  assign word_sel = grant_a ? queue_word_t'(aData) : queue_word_t'(bData);

  // Next-state and next ring-slot selection.
  always_comb begin
    state_next = state;
    burst_next = burst;
    wd_next    = wd;
    ring_next  = '0;
    type_next  = SLOT_NULL;
    src_next   = '0;
    lost_next  = 1'b0;
    case (state)
      ST_INJECT: begin
        if (emit_token) begin
          ring_next  = {28'd0, burst};
          type_next  = SLOT_TOKEN;
          state_next = ST_WAIT_TOKEN;
          burst_next = '0;
          wd_next    = '0;
        end else begin
          // Queue dest field occupies the source lane of the injected slot.
          ring_next  = word_sel.data;
          type_next  = word_sel.kind;
          src_next   = word_sel.dest;
          burst_next = burst + 4'd1;
        end
      end
      ST_WAIT_TOKEN: begin
        wd_next = wd + 16'd1;
        if (token_in) begin
          state_next = ST_INJECT;
        end else begin
          if (!drop_addr) begin
            ring_next = ringIn;
            type_next = slotTypeIn;
            src_next  = sourceIn;
          end
          if (wd == TIMEOUT_LAST) begin
            lost_next  = 1'b1;
            state_next = ST_INJECT;
          end
        end
      end
      default: state_next = ST_INJECT;
    endcase
  end

  // State and registered ring-head outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INJECT;
      burst       <= '0;
      wd          <= '0;
      ringOut     <= '0;
      slotTypeOut <= SLOT_NULL;
      sourceOut   <= '0;
      tokenLost   <= 1'b0;
    end else begin
      state       <= state_next;
      burst       <= burst_next;
      wd          <= wd_next;
      ringOut     <= ring_next;
      slotTypeOut <= type_next;
      sourceOut   <= src_next;
      tokenLost   <= lost_next;
    end
  end

`ifdef RING_SLOT_SCHED_STATS_EN
  // Grant and round statistics, free-running with natural wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      statA      <= '0;
      statB      <= '0;
      statRounds <= '0;
    end else begin
      if (grant_a)    statA      <= statA + 32'd1;
      if (grant_b)    statB      <= statB + 32'd1;
      if (emit_token) statRounds <= statRounds + 32'd1;
    end
  end
`else
  assign statA      = '0;
  assign statB      = '0;
  assign statRounds = '0;
`endif

  logic unused_pri;
  assign unused_pri = pri_b;

endmodule

// File: tb/tb_ring_slot_sched.sv
// Self-checking bench for ring_slot_sched: directed table and sequences plus
// randomized traffic compared against a round-level reference model.
module tb_ring_slot_sched;
  import ring_pkg::*;

  localparam int unsigned MB = 8;
  localparam int unsigned TT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ringIn;
  logic [3:0]  slotTypeIn, sourceIn;
  logic [31:0] ringOut;
  logic [3:0]  slotTypeOut, sourceOut;
  logic        aValid, bValid, aRead, bRead, tokenLost;
  logic [39:0] aData, bData;
  logic [31:0] statA, statB, statRounds;

  always #5 clock = ~clock;

  ring_slot_sched #(.MAX_BURST(MB), .TOKEN_TIMEOUT(TT)) dut (
    .clock(clock), .reset(reset),
    .ringIn(ringIn), .slotTypeIn(slotTypeIn), .sourceIn(sourceIn),
    .ringOut(ringOut), .slotTypeOut(slotTypeOut), .sourceOut(sourceOut),
    .aValid(aValid), .aData(aData), .aRead(aRead),
    .bValid(bValid), .bData(bData), .bRead(bRead),
    .tokenLost(tokenLost), .statA(statA), .statB(statB), .statRounds(statRounds)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] qa[$];
  logic [39:0] qb[$];

  // Reference model: a round is "injecting" or "waiting for token".
  bit          m_wait;
  int          m_burst;
  bit          m_pri_b;
  int          m_wait_cycles;
  int unsigned m_sa, m_sb, m_sr;
  bit          e_ar, e_br, e_lost;
  logic [31:0] e_ring;
  logic [3:0]  e_type, e_src;
  int          wait_seen;

  typedef struct {
    logic [3:0]  t;  logic [31:0] d;  logic [3:0] s;
    logic [3:0]  et; logic [31:0] ed; logic [3:0] es;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh_inputs();
    aValid = (qa.size() > 0);
    bValid = (qb.size() > 0);
    aData  = aValid ? qa[0] : '0;
    bData  = bValid ? qb[0] : '0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_burst = 0; m_pri_b = 0; m_wait_cycles = 0;
    m_sa = 0; m_sb = 0; m_sr = 0;
  endtask

  task automatic model_step();
    bit take_a;
    logic [39:0] w;
    e_ar = 0; e_br = 0; e_lost = 0;
    e_ring = '0; e_type = 4'd7; e_src = '0;
    if (!m_wait) begin
      if (m_burst == int'(MB) || (qa.size() == 0 && qb.size() == 0)) begin
        e_ring = 32'(m_burst); e_type = 4'd1;
        m_wait = 1; m_burst = 0; m_pri_b = !m_pri_b; m_wait_cycles = 0; m_sr++;
      end else begin
        take_a = m_pri_b ? (qb.size() == 0) : (qa.size() != 0);
        w = take_a ? qa[0] : qb[0];
        e_ar = take_a; e_br = !take_a;
        e_ring = w[31:0]; e_type = w[35:32]; e_src = w[39:36];
        m_burst++;
        if (take_a) m_sa++; else m_sb++;
      end
    end else if (slotTypeIn == 4'd1) begin
      m_wait = 0;
    end else begin
      if (!(slotTypeIn == 4'd2 && ringIn[31])) begin
        e_ring = ringIn; e_type = slotTypeIn; e_src = sourceIn;
      end
      if (m_wait_cycles == int'(TT) - 1) begin
        e_lost = 1; m_wait = 0;
      end else begin
        m_wait_cycles++;
      end
    end
  endtask

  task automatic check_stats();
`ifdef RING_SLOT_SCHED_STATS_EN
    check("statA", 64'(statA), 64'(m_sa));
    check("statB", 64'(statB), 64'(m_sb));
    check("statRounds", 64'(statRounds), 64'(m_sr));
`else
    check("stats_off", {statA, statB}, 64'(statRounds));
    check("statRounds_off", 64'(statRounds), 64'd0);
`endif
  endtask

  task automatic tick(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    slotTypeIn = t; ringIn = d; sourceIn = s;
    @(negedge clock);
    model_step();
    check("aRead", 64'(aRead), 64'(e_ar));
    check("bRead", 64'(bRead), 64'(e_br));
    @(posedge clock);
    #1;
    check("slot", 64'({ringOut, slotTypeOut, sourceOut}), 64'({e_ring, e_type, e_src}));
    check("tokenLost", 64'(tokenLost), 64'(e_lost));
    if (e_ar) void'(qa.pop_front());
    if (e_br) void'(qb.pop_front());
    refresh_inputs();
  endtask

  task automatic do_reset(input int n);
    reset = 1; slotTypeIn = 4'd7; ringIn = '0; sourceIn = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("rst_pops", 64'({aRead, bRead}), 64'd0);
      @(posedge clock);
      #1;
      check("rst_slot", 64'({ringOut, slotTypeOut, sourceOut}), 64'({32'd0, 4'd7, 4'd0}));
      check("rst_lost", 64'(tokenLost), 64'd0);
    end
    model_reset();
    check_stats();
    reset = 0;
  endtask

  // Runs traffic, returning the Token after two waiting cycles.
  task automatic run_rounds(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (m_wait && wait_seen >= 2) begin
        tick(4'd1, 32'd0, 4'd0); wait_seen = 0;
      end else begin
        if (m_wait) wait_seen++;
        tick(4'd7, 32'd0, 4'd0);
      end
    end
  endtask

  function automatic logic [39:0] rand_word(input int tag);
    logic [3:0] k;
    k = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd3;
    return {4'($urandom_range(0, 15)), k, 32'($urandom) ^ 32'(tag)};
  endfunction

  initial begin
    int pops, pulses;
    vecs[0] = '{4'd2, 32'h8000_0010, 4'd5, 4'd7, 32'h0, 4'd0};
    vecs[1] = '{4'd2, 32'h0000_0010, 4'd5, 4'd2, 32'h0000_0010, 4'd5};
    vecs[2] = '{4'd3, 32'h0000_1234, 4'd9, 4'd3, 32'h0000_1234, 4'd9};
    vecs[3] = '{4'd7, 32'h0, 4'd0, 4'd7, 32'h0, 4'd0};
    vecs[4] = '{4'd3, 32'h8000_0000, 4'd2, 4'd3, 32'h8000_0000, 4'd2};
    vecs[5] = '{4'd2, 32'hFFFF_FFFF, 4'd15, 4'd7, 32'h0, 4'd0};
    wait_seen = 0;
    refresh_inputs();
    do_reset(3);

    // Empty queues: Token with data 0, Token back after 5 cycles.
    tick(4'd7, 32'd0, 4'd0);
    check("first_token", 64'({ringOut, slotTypeOut}), 64'({32'd0, 4'd1}));
    repeat (4) tick(4'd7, 32'd0, 4'd0);
    tick(4'd1, 32'd0, 4'd0);
    check("token_to_null", 64'(slotTypeOut), 64'd7);
    tick(4'd7, 32'd0, 4'd0);
    check("reinject_token", 64'(slotTypeOut), 64'd1);

    // Waiting-state filter table.
    foreach (vecs[i]) begin
      tick(vecs[i].t, vecs[i].d, vecs[i].s);
      check("table", 64'({ringOut, slotTypeOut, sourceOut}),
            64'({vecs[i].ed, vecs[i].et, vecs[i].es}));
    end
    tick(4'd1, 32'd0, 4'd0);

    // Three A words then Token carrying 3.
    for (int i = 0; i < 3; i++) qa.push_back({4'd3, 4'd3, 32'(32'hA000 + i)});
    refresh_inputs();
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      tick(4'd7, 32'd0, 4'd0);
      if (e_ar) pops++;
      check("a_order", 64'(ringOut), 64'(32'hA000 + i));
    end
    check("a_pops", 64'(pops), 64'd3);
    tick(4'd7, 32'd0, 4'd0);
    check("token3", 64'({ringOut, slotTypeOut}), 64'({32'd3, 4'd1}));
    check_stats();
    tick(4'd1, 32'd0, 4'd0);

    // Both queues with 10 entries, bursts capped at 8.
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      qa.push_back({4'd1, 4'd3, 32'(32'hAA00 + i)});
      qb.push_back({4'd2, 4'd3, 32'(32'hBB00 + i)});
    end
    refresh_inputs();
    for (int i = 0; i < 8; i++) tick(4'd7, 32'd0, 4'd0);
    check("r1_last_a", 64'({ringOut, sourceOut}), 64'({32'hAA07, 4'd1}));
    tick(4'd7, 32'd0, 4'd0);
    check("token8", 64'({ringOut, slotTypeOut}), 64'({32'd8, 4'd1}));
    tick(4'd1, 32'd0, 4'd0);
    tick(4'd7, 32'd0, 4'd0);
    check("r2_first_b", 64'({ringOut, sourceOut}), 64'({32'hBB00, 4'd2}));
    wait_seen = 0;
    run_rounds(30);
    check_stats();

    // Watchdog: no Token -> pulse on the 16th waiting cycle; then Token on that cycle.
    do_reset(1);
    tick(4'd7, 32'd0, 4'd0);
    pulses = 0;
    for (int i = 1; i <= int'(TT); i++) begin
      tick(4'd3, 32'(i), 4'd1);
      if (tokenLost) begin
        pulses++;
        check("lost_cycle", 64'(i), 64'(TT));
      end
    end
    check("lost_pulses", 64'(pulses), 64'd1);
    tick(4'd7, 32'd0, 4'd0);
    check("regen_token", 64'(slotTypeOut), 64'd1);
    for (int i = 1; i < int'(TT); i++) tick(4'd7, 32'd0, 4'd0);
    tick(4'd1, 32'd0, 4'd0);
    check("no_lost_on_token", 64'({tokenLost, slotTypeOut}), 64'({1'b0, 4'd7}));

    // Reset mid-burst after 2 of 5 A words, while priority sits on B.
    do_reset(1);
    tick(4'd7, 32'd0, 4'd0);
    tick(4'd1, 32'd0, 4'd0);
    for (int i = 0; i < 5; i++) qa.push_back({4'd4, 4'd3, 32'(32'hC000 + i)});
    refresh_inputs();
    tick(4'd7, 32'd0, 4'd0);
    tick(4'd7, 32'd0, 4'd0);
    do_reset(2);
    for (int i = 0; i < 3; i++) qb.push_back({4'd5, 4'd3, 32'(32'hD000 + i)});
    refresh_inputs();
    tick(4'd7, 32'd0, 4'd0);
    check("post_rst_pri_a", 64'({ringOut, sourceOut}), 64'({32'hC002, 4'd4}));
    wait_seen = 0;
    run_rounds(20);
    check_stats();

    // Randomized traffic.
    do_reset(1);
    for (int c = 0; c < 1500; c++) begin
      int r;
      logic [3:0] t;
      if ($urandom_range(0, 3) == 0 && qa.size() < 20) qa.push_back(rand_word(c));
      if ($urandom_range(0, 4) == 0 && qb.size() < 20) qb.push_back(rand_word(c + 7));
      refresh_inputs();
      r = int'($urandom_range(0, 99));
      t = (r < 7) ? 4'd1 : (r < 40) ? 4'd2 : (r < 70) ? 4'd3 : (r < 90) ? 4'd7 : 4'd5;
      tick(t, $urandom, 4'($urandom_range(0, 15)));
      if (c == 900) do_reset(2);
    end
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ring_slot_sched.md
RING_SLOT_SCHED -- requirements
Module: ring_slot_sched

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: max words injected per token round (1..15).
REQ-002 SHALL have parameter TOKEN_TIMEOUT, default 1024: WAIT_TOKEN cycles before token regeneration (2..65535).
REQ-003 SHALL have ports: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: ringIn  in  32  slot data from last core; slotTypeIn  in  4  slot type; sourceIn  in  4  slot source.
REQ-005 SHALL have ports: ringOut  out  32; slotTypeOut  out  4; sourceOut  out  4; all registered, driving ring position 0.
REQ-006 SHALL have ports: aValid  in  1  resend queue non-empty; aData  in  40  {dest,type,data}; aRead  out  1  pop strobe.
REQ-007 SHALL have ports: bValid  in  1  directory-notify queue non-empty; bData  in  40  {dest,type,data}; bRead  out  1  pop strobe.
REQ-008 SHALL have ports: tokenLost  out  1  one-cycle pulse on timeout; statA, statB, statRounds  out  32 each  statistics.

Function
REQ-009 SHALL implement two states: INJECT and WAIT_TOKEN; exactly one slot is emitted per cycle in every state.
REQ-010 In INJECT, grant SHALL go to the round's priority requester if valid, else the other; aRead/bRead asserted combinationally that cycle, same data registered onto ring outputs at the next edge.
REQ-011 aRead and bRead SHALL never both be asserted; neither asserted outside INJECT.
REQ-012 Priority SHALL start with A after reset and toggle at every Token emission.
REQ-013 A 4-bit burst counter SHALL count injected words; when neither requester is valid or the counter equals MAX_BURST, emit Token (type 1) with ringOut = burst count, sourceOut = 0, zero pops, clear counter, enter WAIT_TOKEN.
REQ-014 In WAIT_TOKEN, an incoming Token SHALL be replaced by Null (type 7, data 0, source 0) and the state SHALL return to INJECT next cycle.
REQ-015 In WAIT_TOKEN, an Address slot (type 2) with ringIn[31]=1 SHALL be replaced by Null; every other slot SHALL pass through unchanged with one cycle latency.
REQ-016 A 16-bit watchdog SHALL clear on entering WAIT_TOKEN and increment each WAIT_TOKEN cycle; at TOKEN_TIMEOUT-1 with no Token that cycle: pulse tokenLost, emit pass-through per REQ-015, enter INJECT.
REQ-017 Token arrival on the timeout cycle SHALL take precedence: no tokenLost pulse.
REQ-018 In INJECT, incoming ring slots SHALL be discarded (ring head owned by scheduler).
REQ-019 Requester valids changing mid-round SHALL be sampled per cycle; no word shall be lost or duplicated.

Reset
REQ-020 On reset: state INJECT, priority A, burst and watchdog 0, ringOut 0, slotTypeOut Null, sourceOut 0, tokenLost 0, aRead/bRead 0, statistics 0.
REQ-021 Reset asserted mid-round SHALL abandon the round; no pop strobe asserted during reset cycles.

Configuration
REQ-022 With RING_SLOT_SCHED_STATS_EN defined: statA/statB count words granted per requester, statRounds counts Token emissions, all wrapping at 2^32.
REQ-023 Without RING_SLOT_SCHED_STATS_EN: statA, statB, statRounds SHALL be constant 0 and no counter flops inferred.

Structure
REQ-024 Slot type constants (Token=1, Address=2, WriteData=3, Null=7) and the state encoding SHALL reside in shared package ring_pkg.
REQ-025 Two-input priority/toggle grant logic SHALL be one sub-module, ring_rr_arb; watchdog and datapath stay in ring_slot_sched.

Verification
REQ-026 Reset release, both queues empty -> first slot Token data 0; WAIT_TOKEN; ringIn Token after 5 cycles -> Null out, INJECT next cycle.
REQ-027 A holds 3 entries, B empty -> 3 aRead pulses, 3 words out in order, then Token data 3.
REQ-028 A and B each hold 10, MAX_BURST=8 -> round 1: 8 A words, Token data 8; round 2: 8 B words first; no simultaneous pops.
REQ-029 WAIT_TOKEN, ringIn Address 0x8000_0010 -> Null out; Address 0x0000_0010 and WriteData 0x1234 -> passed unchanged one cycle later.
REQ-030 TOKEN_TIMEOUT=16, no Token returned -> tokenLost pulse 16 cycles after Token emission, new Token next round; Token on cycle 16 -> no pulse.
REQ-031 Reset mid-burst after 2 of 5 A words -> Null outputs, no pops during reset, statistics 0, restart from INJECT with priority A.
